// File: rtl/alu_wb_pkg.sv
// rtl/alu_wb_pkg.sv - shared types and sizing helpers for the ALU writeback buffer
package alu_wb_pkg;

   localparam int OPE_W   = 32;
   localparam int TAG_W   = 6;
   localparam int DEPTH_D = 8;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [OPE_W-1:0] result;
   } wb_entry_t;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/alu_wb_mem.sv
// rtl/alu_wb_mem.sv - entry storage, two write ports and one asynchronous read port
import alu_wb_pkg::*;

module alu_wb_mem #(
   parameter int DEPTH = DEPTH_D,
   localparam int AW   = ptr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          wa_en,
   input  logic [AW-1:0] wa_addr,
   input  wb_entry_t     wa_data,
   input  logic          wb_en,
   input  logic [AW-1:0] wb_addr,
   input  wb_entry_t     wb_data,
   input  logic [AW-1:0] rd_addr,
   output wb_entry_t     rd_data
);

   wb_entry_t mem [DEPTH];

   // The two write addresses are always distinct when both enables are set.
   always_ff @(posedge clk) begin
      if (wa_en) mem[wa_addr] <= wa_data;
      if (wb_en) mem[wb_addr] <= wb_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_wb_buffer.sv
// rtl/alu_wb_buffer.sv - two-in, one-out in-order completion buffer feeding the ROB
import alu_wb_pkg::*;

module alu_wb_buffer #(
   parameter int OPE   = OPE_W,
   parameter int TAG   = TAG_W,
   parameter int DEPTH = DEPTH_D,
   localparam int AW   = ptr_width(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in1_valid,
   input  logic [TAG-1:0] in1_tag,
   input  logic [OPE-1:0] in1_result,
   input  logic           in2_valid,
   input  logic [TAG-1:0] in2_tag,
   input  logic [OPE-1:0] in2_result,
   output logic           in_ready,
   output logic           out_valid,
   output logic [TAG-1:0] out_tag,
   output logic [OPE-1:0] out_result,
   input  logic           out_ready,
   output logic [CW-1:0]  count,
   output logic           overflow_err
);

   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] cnt;
   logic          acc1, acc2, pop;
   logic [CW-1:0] n_push;
   wb_entry_t     head, wa_data, wb_data;
   logic [AW-1:0] wb_addr;

   // Readiness comes from registered occupancy only, so issue never sees out_ready.
   assign in_ready  = (cnt <= CW'(DEPTH - 2));
   assign out_valid = (cnt != '0);
   assign pop       = out_valid & out_ready;
   assign acc1      = in1_valid & in_ready;
   assign acc2      = in2_valid & in_ready;
   assign n_push    = CW'(acc1) + CW'(acc2);
   assign wb_addr   = acc1 ? wr_ptr + AW'(1) : wr_ptr;
   assign wa_data   = '{tag: in1_tag, result: in1_result};
   assign wb_data   = '{tag: in2_tag, result: in2_result};

   alu_wb_mem #(.DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .wa_en   (acc1),
      .wa_addr (wr_ptr),
      .wa_data (wa_data),
      .wb_en   (acc2),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         cnt          <= '0;
         overflow_err <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + n_push[AW-1:0];
         rd_ptr <= rd_ptr + AW'(pop);
         cnt    <= cnt + n_push - CW'(pop);
         if ((in1_valid | in2_valid) & ~in_ready)
            overflow_err <= 1'b1;
      end
   end

   assign count      = cnt;
   assign out_tag    = out_valid ? head.tag    : '0;
   assign out_result = out_valid ? head.result : '0;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// tb/tb_alu_wb_buffer.sv - queue-model scoreboard bench for alu_wb_buffer
module tb_alu_wb_buffer;

   localparam int OPE   = 32;
   localparam int TAG   = 6;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic           clk = 1'b0;
   logic           rst;
   logic           in1_valid, in2_valid, out_ready;
   logic [TAG-1:0] in1_tag, in2_tag;
   logic [OPE-1:0] in1_result, in2_result;
   logic           in_ready, out_valid, overflow_err;
   logic [TAG-1:0] out_tag;
   logic [OPE-1:0] out_result;
   logic [CW-1:0]  count;

   alu_wb_buffer #(.OPE(OPE), .TAG(TAG), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .in1_valid    (in1_valid),
      .in1_tag      (in1_tag),
      .in1_result   (in1_result),
      .in2_valid    (in2_valid),
      .in2_tag      (in2_tag),
      .in2_result   (in2_result),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_tag      (out_tag),
      .out_result   (out_result),
      .out_ready    (out_ready),
      .count        (count),
      .overflow_err (overflow_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TAG-1:0] tag;
      logic [OPE-1:0] res;
   } exp_t;

   exp_t q[$];
   bit   ovf_m = 1'b0;
   bit   armed = 1'b0;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of accepted results, updated on each clock edge.
   always @(posedge clk) begin
      bit acc;
      exp_t e;
      if (rst) begin
         q.delete();
         ovf_m = 1'b0;
         armed = 1'b1;
      end else if (armed) begin
         acc = (DEPTH - q.size()) >= 2;
         if (q.size() != 0 && out_ready) void'(q.pop_front());
         if ((in1_valid || in2_valid) && !acc) ovf_m = 1'b1;
         if (acc && in1_valid) begin
            e.tag = in1_tag; e.res = in1_result; q.push_back(e);
         end
         if (acc && in2_valid) begin
            e.tag = in2_tag; e.res = in2_result; q.push_back(e);
         end
      end
   end

   // Monitor: compares every presented output against the model head.
   always @(negedge clk) begin
      if (armed) begin
         chk("count", 64'(count), 64'(q.size()));
         chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("in_ready", 64'(in_ready), 64'((DEPTH - q.size()) >= 2));
         chk("overflow_err", 64'(overflow_err), 64'(ovf_m));
         if (q.size() != 0) begin
            chk("out_tag", 64'(out_tag), 64'(q[0].tag));
            chk("out_result", 64'(out_result), 64'(q[0].res));
         end else begin
            chk("out_tag_empty", 64'(out_tag), 64'd0);
            chk("out_result_empty", 64'(out_result), 64'd0);
         end
      end
   end

   task automatic step(input logic r, input logic v1, input logic [TAG-1:0] t1, input logic [OPE-1:0] d1,
                       input logic v2, input logic [TAG-1:0] t2, input logic [OPE-1:0] d2, input logic ordy);
      rst = r; in1_valid = v1; in1_tag = t1; in1_result = d1;
      in2_valid = v2; in2_tag = t2; in2_result = d2; out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ordy);
   endtask

   initial begin
      step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      rst = 1'b0;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_overflow", 64'(overflow_err), 64'd0);

      // Dual push, single drain
      step(1'b0, 1'b1, 6'd3, 32'h11, 1'b1, 6'd4, 32'h22, 1'b1);
      chk("dual_c1_tag", 64'(out_tag), 64'd3);
      chk("dual_c1_res", 64'(out_result), 64'h11);
      idle(1'b1);
      chk("dual_c2_tag", 64'(out_tag), 64'd4);
      chk("dual_c2_res", 64'(out_result), 64'h22);
      idle(1'b1);
      chk("dual_c3_valid", 64'(out_valid), 64'd0);

      // Lane-2-only push
      step(1'b0, 1'b0, '0, '0, 1'b1, 6'd9, 32'hABCD, 1'b0);
      chk("lane2_tag", 64'(out_tag), 64'd9);
      chk("lane2_res", 64'(out_result), 64'hABCD);
      chk("lane2_count", 64'(count), 64'd1);
      idle(1'b1);

      // Fill with back-pressure
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 6'(10 + 2*i), 32'(100 + 2*i), 1'b1, 6'(11 + 2*i), 32'(101 + 2*i), 1'b0);
      chk("fill6_count", 64'(count), 64'd6);
      chk("fill6_ready", 64'(in_ready), 64'd1);
      step(1'b0, 1'b1, 6'd16, 32'd106, 1'b1, 6'd17, 32'd107, 1'b0);
      chk("full_count", 64'(count), 64'd8);
      chk("full_ready", 64'(in_ready), 64'd0);
      chk("full_head_tag", 64'(out_tag), 64'd10);
      chk("full_head_res", 64'(out_result), 64'd100);

      // Overflow while full, then sustained push/pop across the wrap
      step(1'b0, 1'b1, 6'd40, 32'hDEAD, 1'b0, '0, '0, 1'b0);
      chk("ovf_count", 64'(count), 64'd8);
      chk("ovf_flag", 64'(overflow_err), 64'd1);
      idle(1'b1);
      idle(1'b1);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, (i % 2) == 0, 6'(20 + i), 32'(1000 + i), (i % 2) == 1, 6'(20 + i), 32'(1000 + i), 1'b1);
         chk("wrap_count", 64'(count), 64'd6);
      end
      chk("ovf_sticky", 64'(overflow_err), 64'd1);

      // Reset mid-flight with concurrent push and pop
      idle(1'b1);
      chk("pre_rst_count", 64'(count), 64'd5);
      step(1'b1, 1'b1, 6'd50, 32'h55, 1'b0, '0, '0, 1'b1);
      chk("midrst_count", 64'(count), 64'd0);
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_ovf", 64'(overflow_err), 64'd0);

      // Randomized traffic, mostly honouring the model's room
      for (int i = 0; i < 400; i++) begin
         logic v1, v2, room;
         room = (DEPTH - q.size()) >= 2;
         v1 = ($urandom_range(0, 99) < 60);
         v2 = ($urandom_range(0, 99) < 45);
         if (!room && $urandom_range(0, 99) < 90) begin
            v1 = 1'b0;
            v2 = 1'b0;
         end
         step(($urandom_range(0, 199) == 0), v1, 6'($urandom), $urandom, v2, 6'($urandom), $urandom,
              ($urandom_range(0, 99) < 55));
      end
      idle(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
